// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional parity (`UART_TX_PARITY_EN), stop bit(s).
// Latency: accept to tx_done = 2 + DATA_BITS + parity + STOP_BITS baud ticks; tx/tx_done registered.
// Backpressure: tx_ready is high only in IDLE; tx_valid while not ready is dropped, never queued.
module uart_tx_serializer #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_tick,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [7:0] DATA_MASK = 8'((16'd1 << DATA_BITS) - 16'd1);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t     state_q;
  logic [7:0] shift_q;
  logic [2:0] bit_cnt_q;
  logic       stop_cnt_q;
  logic       tx_q;
  logic       tx_done_q;

`ifdef UART_TX_PARITY_EN
  logic       par_q;
`else
  logic       unused_parity_odd;
  assign unused_parity_odd = 1'(PARITY_ODD);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      tx_done_q <= 1'b0;
      case (state_q)
        // A tick coinciding with acceptance is ignored: ALIGN waits for the next one.
        S_IDLE: begin
          if (tx_valid) begin
            shift_q <= tx_data & DATA_MASK;
`ifdef UART_TX_PARITY_EN
            par_q   <= (^(tx_data & DATA_MASK)) ^ 1'(PARITY_ODD);
`endif
            state_q <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          if (baud_tick) begin
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (baud_tick) begin
            tx_q      <= shift_q[0];
            bit_cnt_q <= '0;
            state_q   <= S_DATA;
          end
        end
        S_DATA: begin
          if (baud_tick) begin
            if (bit_cnt_q != LAST_BIT) begin
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end else begin
`ifdef UART_TX_PARITY_EN
              tx_q    <= par_q;
              state_q <= S_PARITY;
`else
              tx_q       <= 1'b1;
              stop_cnt_q <= 1'b0;
              state_q    <= S_STOP;
`endif
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_tick) begin
            tx_q       <= 1'b1;
            stop_cnt_q <= 1'b0;
            state_q    <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (baud_tick) begin
            if (stop_cnt_q == LAST_STOP) begin
              tx_done_q <= 1'b1;
              state_q   <= S_IDLE;
            end else begin
              stop_cnt_q <= stop_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_ready = (state_q == S_IDLE);
  assign tx_busy  = (state_q != S_IDLE);
  assign tx       = tx_q;
  assign tx_done  = tx_done_q;

endmodule
